axi_burst_tester: RTL
=====================

AXI_BURST_TESTER -- requirements
Module: axi_burst_tester

Interface
REQ-001 SHALL have parameter TID, default 4'h1, the AWID/ARID value driven on every burst.
REQ-002 SHALL have parameter SEED, default 32'h0000_0000, XOR-ed into every data-pattern word.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports start (in, 1), base_addr (in, 32), num_bursts (in, 16) and burst_len (in, 8); burst_len is AXI LEN, so beats = burst_len+1.
REQ-006 SHALL have ports busy (out, 1), done (out, 1), pass (out, 1), err_count (out, 16) and resp_err (out, 1).
REQ-007 SHALL have AXI write-address ports AWADDR (out, 32), AWID (out, 4), AWLEN (out, 8), AWVALID (out, 1) and AWREADY (in, 1).
REQ-008 SHALL have AXI write-data ports WID (out, 4), WDATA (out, 512), WSTRB (out, 64), WLAST (out, 1), WVALID (out, 1) and WREADY (in, 1).
REQ-009 SHALL have AXI write-response ports BID (in, 4), BRESP (in, 2), BVALID (in, 1) and BREADY (out, 1).
REQ-010 SHALL have AXI read ports ARADDR (out, 32), ARID (out, 4), ARLEN (out, 8), ARVALID (out, 1), ARREADY (in, 1), RID (in, 4), RDATA (in, 512), RRESP (in, 2), RLAST (in, 1), RVALID (in, 1) and RREADY (out, 1).

Function
REQ-011 SHALL run FSM states IDLE, AW, W, B, AR, R, NEXT and DONE.
REQ-012 SHALL, in IDLE with start=1, latch base_addr with bits[5:0] forced to 0, latch num_bursts and burst_len, clear err_count and resp_err, and go to AW; if num_bursts=0 it SHALL go to DONE instead.
REQ-013 SHALL ignore start in every state except IDLE and DONE; start in DONE SHALL behave as in IDLE.
REQ-014 SHALL compute burst address = latched base + burst_idx*(burst_len+1)*64, truncated to 32 bits (wraps modulo 2^32).
REQ-015 SHALL, in AW, drive AWVALID=1 with AWADDR, AWID=TID and AWLEN stable until AWREADY=1, then go to W.
REQ-016 SHALL, in W, hold WVALID=1, WID=TID and WSTRB=all ones; each WVALID&WREADY SHALL advance the beat counter, and WDATA SHALL hold until accepted.
REQ-017 SHALL drive WDATA with 16 identical 32-bit words, each = (burst address + 64*beat) XOR SEED.
REQ-018 SHALL assert WLAST exactly when beat = burst_len, and SHALL go to B after the last beat is accepted.
REQ-019 SHALL, in B, assert BREADY=1; on BVALID it SHALL go to AR, and BRESP!=0 or BID!=TID SHALL set resp_err and add 1 to err_count.
REQ-020 SHALL, in AR, drive ARVALID, ARADDR, ARID and ARLEN identical to the write burst until ARREADY=1, then go to R.
REQ-021 SHALL, in R, assert RREADY=1; each RVALID beat SHALL be compared as 512 bits against the REQ-017 pattern for that beat, and a mismatch SHALL add 1 to err_count.
REQ-022 SHALL, on any R beat, treat RRESP!=0 or RID!=TID as setting resp_err and adding 1 to err_count; these checks are separate from the data compare.
REQ-023 SHALL treat RLAST=0 on beat burst_len as 1 error, continue accepting beats until RLAST=1, and RLAST=1 on an earlier beat SHALL count 1 error and end the burst.
REQ-024 SHALL make err_count saturate at 16'hFFFF, and several error sources on one beat SHALL add only 1.
REQ-025 SHALL, in NEXT, increment burst_idx, go to AW if burst_idx+1 < num_bursts, else go to DONE; NEXT SHALL last one cycle.
REQ-026 SHALL, in DONE, hold done=1 and pass=(err_count==0 & !resp_err) until start.
REQ-027 SHALL drive busy=1 in every state except IDLE and DONE.
REQ-028 SHALL drive all AXI valid/ready outputs from registered state, with no combinational path from AXI inputs to AXI outputs.

Reset
REQ-029 SHALL, while reset=1 (asynchronous), force state IDLE, and all valid/ready, busy, done, pass, resp_err, err_count, burst_idx and beat counters to 0.
REQ-030 SHALL abandon any burst on reset mid-operation, with no further beats after release, and SHALL not start again until a new start.

Verification
REQ-031 SHALL pass bench case 1: zero-wait RAM slave, base=0x1000, num_bursts=2, burst_len=3 -> AW at 0x1000 then 0x1100, 4 beats each with WLAST on beat 3, done=1, pass=1, err_count=0.
REQ-032 SHALL pass bench case 2: slave with random 0-30 cycle READY/VALID stalls, num_bursts=4, burst_len=15 -> WDATA stable while stalled, pass=1.
REQ-033 SHALL pass bench case 3: slave corrupting bit 0 of RDATA on beat 2 of burst 0 -> err_count=1, pass=0, resp_err=0.
REQ-034 SHALL pass bench case 4: slave returning BRESP=2'b10 once, and RLAST one beat early on another burst -> err_count=2, resp_err=1, pass=0.
REQ-035 SHALL pass bench case 5: reset pulsed mid W phase -> all outputs 0 in that cycle, then a restart with num_bursts=0 -> done=1 and pass=1 within 2 cycles.

Source files
------------

// File: rtl/axi_burst_tester_if.sv
// AXI write/read channel bundle between the burst tester (master) and a memory slave.
interface axi_burst_tester_if;
  logic [31:0]  AWADDR;
  logic [3:0]   AWID;
  logic [7:0]   AWLEN;
  logic         AWVALID;
  logic         AWREADY;
  logic [3:0]   WID;
  logic [511:0] WDATA;
  logic [63:0]  WSTRB;
  logic         WLAST;
  logic         WVALID;
  logic         WREADY;
  logic [3:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [31:0]  ARADDR;
  logic [3:0]   ARID;
  logic [7:0]   ARLEN;
  logic         ARVALID;
  logic         ARREADY;
  logic [3:0]   RID;
  logic [511:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY;

  modport master (
    output AWADDR, AWID, AWLEN, AWVALID, input AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARADDR, ARID, ARLEN, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWID, AWLEN, AWVALID, output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARADDR, ARID, ARLEN, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_burst_tester.sv
// AXI burst memory tester: writes an address-derived pattern burst by burst,
// reads each burst straight back and counts data / response / framing errors.
module axi_burst_tester #(
  parameter logic [3:0]  TID  = 4'h1,
  parameter logic [31:0] SEED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_bursts,
  input  logic [7:0]  burst_len,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        resp_err,
  axi_burst_tester_if.master axi
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [31:0]  addr_q, addr_d;     // address of the current burst
  logic [15:0]  nb_q, nb_d;
  logic [7:0]   len_q, len_d;
  logic [15:0]  idx_q, idx_d;
  logic [7:0]   beat_q, beat_d;
  logic [15:0]  err_q, err_d;
  logic         rerr_q, rerr_d;
  logic         err_hit, rerr_hit;

  logic [31:0]  beat_addr;
  logic [31:0]  pat_word;
  logic [511:0] pattern;
  logic [31:0]  burst_bytes;
  logic [16:0]  idx_inc;
  logic [5:0]   unused_base;

  // Low address bits are discarded: bursts are always 64-byte aligned.
  assign unused_base = base_addr[5:0];

  // Pattern for the current beat; same expression serves W drive and R compare.
  assign beat_addr   = addr_q + {18'd0, beat_q, 6'd0};
  assign pat_word    = beat_addr ^ SEED;
  assign pattern     = {16{pat_word}};
  assign burst_bytes = ({24'd0, len_q} + 32'd1) << 6;
  assign idx_inc     = {1'b0, idx_q} + 17'd1;

  // All AXI outputs decode from registered state only.
  assign axi.AWADDR  = addr_q;
  assign axi.AWID    = TID;
  assign axi.AWLEN   = len_q;
  assign axi.AWVALID = (state_q == S_AW);
  assign axi.WID     = TID;
  assign axi.WDATA   = pattern;
  assign axi.WSTRB   = {64{state_q == S_W}};
  assign axi.WLAST   = (state_q == S_W) && (beat_q == len_q);
  assign axi.WVALID  = (state_q == S_W);
  assign axi.BREADY  = (state_q == S_B);
  assign axi.ARADDR  = addr_q;
  assign axi.ARID    = TID;
  assign axi.ARLEN   = len_q;
  assign axi.ARVALID = (state_q == S_AR);
  assign axi.RREADY  = (state_q == S_R);

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 16'd0) && !rerr_q;
  assign err_count = err_q;
  assign resp_err  = rerr_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      nb_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state and error accounting; at most one error is charged per beat.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    nb_d     = nb_q;
    len_d    = len_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    err_d    = err_q;
    rerr_d   = rerr_q;
    err_hit  = 1'b0;
    rerr_hit = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = {base_addr[31:6], 6'd0};
          nb_d    = num_bursts;
          len_d   = burst_len;
          idx_d   = '0;
          beat_d  = '0;
          err_d   = '0;
          rerr_d  = 1'b0;
          state_d = (num_bursts == 16'd0) ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        if (axi.AWREADY) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (axi.WREADY) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) state_d = S_B;
        end
      end
      S_B: begin
        if (axi.BVALID) begin
          if (axi.BRESP != 2'b00 || axi.BID != TID) begin
            err_hit  = 1'b1;
            rerr_hit = 1'b1;
          end
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (axi.ARREADY) begin
          beat_d  = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (axi.RVALID) begin
          if (axi.RRESP != 2'b00 || axi.RID != TID) begin
            err_hit  = 1'b1;
            rerr_hit = 1'b1;
          end
          if (axi.RDATA != pattern) err_hit = 1'b1;
          // Missing RLAST on the final beat, or RLAST arriving early.
          if (beat_q == len_q && !axi.RLAST) err_hit = 1'b1;
          if (beat_q <  len_q &&  axi.RLAST) err_hit = 1'b1;
          beat_d = beat_q + 8'd1;
          if (axi.RLAST) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d   = idx_inc[15:0];
        addr_d  = addr_q + burst_bytes;
        state_d = (idx_inc < {1'b0, nb_q}) ? S_AW : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (err_hit && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    if (rerr_hit) rerr_d = 1'b1;
  end

endmodule
